// File: rtl/csi2tx_lb_reg_bank.sv
// CSI-2 TX local-bus register bank: six 32-bit registers behind a one-wait-state
// AHB-style strobe interface, with sticky status events and a registered interrupt.
module csi2tx_lb_reg_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] VERSION   = 32'h0001_0300
) (
    input  logic        clk_ahb,
    input  logic        rstahb,
    input  logic        lb_cs,
    input  logic        lb_adsm,
    input  logic        lb_wrout,
    input  logic [3:0]  lb_beout,
    input  logic [31:0] lb_aout,
    input  logic [31:0] lb_dout,
    input  logic [7:0]  sts_event,
    output logic [31:0] lb_din,
    output logic        lb_rdyh,
    output logic        ahb_error_flag,
    output logic [31:0] ctrl_reg,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  status, irq_en, sts_clr;
    logic [31:0] scratch, rdata;
    logic [15:0] acc_cnt;
    logic [2:0]  idx;
    logic        addr_ok, legal, take, wr_en, rd_en;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++)
            if (be[b]) res[8*b +: 8] = wdat[8*b +: 8];
        return res;
    endfunction

    // Only word-aligned offsets 0x00..0x14 inside our 256-byte window decode.
    assign idx     = lb_aout[4:2];
    assign addr_ok = (lb_aout[31:8] == BASE_ADDR[31:8]) && (lb_aout[7:5] == 3'd0) &&
                     (lb_aout[1:0] == 2'd0) && (idx <= 3'd5);
    assign legal   = addr_ok && (lb_beout != 4'b0000) && !(lb_wrout && idx[2]);
    assign take    = (state == IDLE) && lb_cs && !rstahb;
    assign wr_en   = take && legal && lb_wrout;
    assign rd_en   = take && legal && lb_adsm && !lb_wrout;
    assign sts_clr = (wr_en && idx == 3'd1 && lb_beout[0]) ? lb_dout[7:0] : 8'h00;

    always_comb begin
        rdata = 32'h0;
        case (idx)
            3'd0:    rdata = ctrl_reg;
            3'd1:    rdata = {24'h0, status};
            3'd2:    rdata = {24'h0, irq_en};
            3'd3:    rdata = scratch;
            3'd4:    rdata = VERSION;
            3'd5:    rdata = {16'h0, acc_cnt};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        lb_rdyh        = 1'b1;
        ahb_error_flag = 1'b0;
        case (state)
            IDLE: begin
                if (lb_cs) begin
                    lb_rdyh        = 1'b0;
                    ahb_error_flag = !legal;
                    state_nxt      = legal ? RESP : ERR;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR: begin
                ahb_error_flag = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A response caught by reset is abandoned silently.
        if (rstahb) begin
            state_nxt      = IDLE;
            lb_rdyh        = 1'b1;
            ahb_error_flag = 1'b0;
        end
    end

    always_ff @(posedge clk_ahb) begin
        if (rstahb) begin
            state    <= IDLE;
            ctrl_reg <= 32'h0;
            status   <= 8'h0;
            irq_en   <= 8'h0;
            scratch  <= 32'h0;
            acc_cnt  <= 16'h0;
            lb_din   <= 32'h0;
            irq      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_en && idx == 3'd0) ctrl_reg <= merge_bytes(ctrl_reg, lb_dout, lb_beout);
            if (wr_en && idx == 3'd2 && lb_beout[0]) irq_en <= lb_dout[7:0];
            if (wr_en && idx == 3'd3) scratch <= merge_bytes(scratch, lb_dout, lb_beout);
            // Event set is applied after the clear so a colliding event wins.
            status <= (status & ~sts_clr) | sts_event;
            irq    <= |(status & irq_en);
            if (take && legal) acc_cnt <= acc_cnt + 16'd1;
            lb_din <= rd_en ? rdata : 32'h0;
        end
    end
endmodule
